// File: rtl/wb4_sync_fifo_w_to_n_if.sv
// Wishbone B4 pipelined write (wide) and read (narrow) port bundle for the
// width-converting sync FIFO.
interface wb4_sync_fifo_w_to_n_if #(
  parameter int P_DATA_MSB = 7,
  parameter int P_RATIO    = 4
);
  localparam int W = P_DATA_MSB + 1;

  logic                 wb4_in_scyc;
  logic                 wb4_in_sstb;
  logic [P_RATIO*W-1:0] wb4_in_sdata;
  logic                 wb4_in_sack;
  logic                 wb4_in_sstall;

  logic                 wb4_out_scyc;
  logic                 wb4_out_sstb;
  logic                 wb4_out_sack;
  logic [W-1:0]         wb4_out_sdata;
  logic                 wb4_out_sstall;

  modport master (
    output wb4_in_scyc, wb4_in_sstb, wb4_in_sdata,
    input  wb4_in_sack, wb4_in_sstall,
    output wb4_out_scyc, wb4_out_sstb,
    input  wb4_out_sack, wb4_out_sdata, wb4_out_sstall
  );

  modport slave (
    input  wb4_in_scyc, wb4_in_sstb, wb4_in_sdata,
    output wb4_in_sack, wb4_in_sstall,
    input  wb4_out_scyc, wb4_out_sstb,
    output wb4_out_sack, wb4_out_sdata, wb4_out_sstall
  );
endinterface

// File: rtl/wb4_sync_fifo_w_to_n.sv
// Single-clock Wishbone B4 FIFO: wide words in, one narrow lane out per
// transfer (lane 0 first), with narrow-unit level, almost flags and flush.
module wb4_sync_fifo_w_to_n #(
  parameter int P_DATA_MSB = 7,
  parameter int P_RATIO    = 4,
  parameter int P_DEPTH    = 16,
  parameter int P_AFULL    = P_DEPTH - 2,
  parameter int P_AEMPTY   = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_flush,
  wb4_sync_fifo_w_to_n_if.slave              bus,
  output logic [$clog2(P_DEPTH*P_RATIO):0]   o_level,
  output logic                               o_almost_full,
  output logic                               o_almost_empty
);
  localparam int W  = P_DATA_MSB + 1;
  localparam int L  = $clog2(P_DEPTH);
  localparam int RB = $clog2(P_RATIO);
  localparam int LI = (RB > 0) ? RB : 1;
  localparam int LW = L + RB + 1;

  logic [P_RATIO*W-1:0] r_mem [P_DEPTH];
  logic [L:0]           r_wptr;
  logic [L:0]           r_rptr;
  logic [LI-1:0]        r_lane;
  logic                 r_in_ack;
  logic                 r_out_ack;
  logic [W-1:0]         r_sdata;

  logic [L:0]           w_entries;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_in_stall;
  logic                 w_out_stall;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_last_lane;
  logic [P_RATIO*W-1:0] w_word;
  logic [LW-1:0]        w_level;

  assign w_entries   = r_wptr - r_rptr;
  assign w_full      = (w_entries == (L+1)'(P_DEPTH));
  assign w_empty     = (w_entries == '0);
  assign w_in_stall  = w_full | i_flush;
  assign w_out_stall = w_empty | i_flush;
  assign w_wr_acc    = bus.wb4_in_scyc & bus.wb4_in_sstb & ~w_in_stall;
  assign w_rd_acc    = bus.wb4_out_scyc & bus.wb4_out_sstb & ~w_out_stall;
  // With a single lane per word the lane index is a constant-zero stub.
  assign w_last_lane = (RB == 0) ? 1'b1 : (r_lane == LI'(P_RATIO - 1));
  assign w_word      = r_mem[r_rptr[L-1:0]];
  assign w_level     = (LW'(w_entries) << RB) - LW'(r_lane);

  assign bus.wb4_in_sack    = r_in_ack;
  assign bus.wb4_in_sstall  = w_in_stall;
  assign bus.wb4_out_sack   = r_out_ack;
  assign bus.wb4_out_sdata  = r_sdata;
  assign bus.wb4_out_sstall = w_out_stall;
  assign o_level            = w_level;
  assign o_almost_full      = (w_entries >= (L+1)'(P_AFULL));
  assign o_almost_empty     = (w_level <= LW'(P_AEMPTY));

  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[r_wptr[L-1:0]] <= bus.wb4_in_sdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_lane    <= '0;
      r_in_ack  <= 1'b0;
      r_out_ack <= 1'b0;
      r_sdata   <= '0;
    end else begin
      r_in_ack  <= w_wr_acc;
      r_out_ack <= w_rd_acc;
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_lane <= '0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + (L+1)'(1);
        if (w_rd_acc) begin
          r_sdata <= w_word[r_lane*W +: W];
          if (w_last_lane) begin
            r_lane <= '0;
            r_rptr <= r_rptr + (L+1)'(1);
          end else begin
            r_lane <= r_lane + LI'(1);
          end
        end
      end
    end
  end
endmodule
